// File: rtl/drm_arb_pkg.sv
// drm_arb_pkg: shared widths and types for the drm_data2 two-master arbiter.
//   ADDR_WIDTH/DATA_WIDTH/BE_WIDTH : RAM geometry defaults (1024 x 8, one byte lane)
//   master_id_t                    : index of a requesting master (0 or 1)
//   ram_wr_t                       : bundle driven onto the RAM write port
package drm_arb_pkg;

    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 8;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    typedef logic master_id_t;

    typedef struct packed {
        logic                  en;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [BE_WIDTH-1:0]   be;
    } ram_wr_t;

endpackage

// File: rtl/drm_rr_arb2.sv
// drm_rr_arb2: two-request round-robin arbiter.
//   clk, rst : clock, synchronous active-high reset (pointer -> master 0)
//   req[1:0] : request per master
//   adv      : a grant was actually taken this cycle; move the pointer
//   grant    : one-hot (or zero) grant, combinational from req and pointer
module drm_rr_arb2
    import drm_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] grant
);

    master_id_t ptr;   // master holding priority this cycle

    always_comb begin
        grant = 2'b00;
        if (req[ptr])
            grant[ptr] = 1'b1;
        else if (req[~ptr])
            grant[~ptr] = 1'b1;
    end

    // After a grant, priority goes to the master that did not win.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (adv && (grant != 2'b00))
            ptr <= master_id_t'(grant[0]);
    end

endmodule

// File: rtl/drm_data2_arb.sv
// drm_data2_arb: two-master access controller for the drm_data2 simple
// dual-port RAM (1024x8, byte enable, read latency 1).
// Independent round-robin per RAM port: one write and one read per cycle.
// Read data returns to the issuing master one cycle after the handshake.
//   clk, rst         : clock and synchronous active-high reset
//   m_req_*          : per-master request channel, packed {m1,m0}
//   m_req_ready      : request accepted this cycle (combinational)
//   m_rsp_valid/rdata: read response, rdata shared and zero when not valid
//   ram_wr_*         : RAM write port
//   ram_rd_addr/data : RAM read port (no enable; address holds when idle)
// Optional build macro DRM_ARB_FWD_EN: a read hitting the address being
// written in the same cycle is granted immediately and the written bytes are
// merged into its response. Without it that read stalls one cycle.
module drm_data2_arb
    import drm_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = drm_arb_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = drm_arb_pkg::DATA_WIDTH,
    parameter int BE_WIDTH   = drm_arb_pkg::BE_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 m_req_valid,
    output logic [1:0]                 m_req_ready,
    input  logic [1:0]                 m_req_we,
    input  logic [1:0][ADDR_WIDTH-1:0] m_req_addr,
    input  logic [1:0][DATA_WIDTH-1:0] m_req_wdata,
    input  logic [1:0][BE_WIDTH-1:0]   m_req_be,
    output logic [1:0]                 m_rsp_valid,
    output logic [DATA_WIDTH-1:0]      m_rsp_rdata,
    output logic                       ram_wr_en,
    output logic [ADDR_WIDTH-1:0]      ram_wr_addr,
    output logic [DATA_WIDTH-1:0]      ram_wr_data,
    output logic [BE_WIDTH-1:0]        ram_wr_byte_en,
    output logic [ADDR_WIDTH-1:0]      ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]      ram_rd_data
);

    logic [1:0]            wr_req, rd_req, wr_gnt, rd_cand, rd_gnt;
    master_id_t            wr_id, rd_id, rsp_id;
    logic                  hazard, rsp_pend;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [DATA_WIDTH-1:0] rsp_data;
    ram_wr_t               wr;

    // Nothing is granted while reset is held.
    assign wr_req = m_req_valid &  m_req_we & {2{~rst}};
    assign rd_req = m_req_valid & ~m_req_we & {2{~rst}};

    drm_rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .req(wr_req), .adv(1'b1),      .grant(wr_gnt));
    drm_rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .req(rd_req), .adv(|rd_gnt),   .grant(rd_cand));

    assign wr_id  = wr_gnt[1];
    assign rd_id  = rd_cand[1];
    assign hazard = (|wr_gnt) && (|rd_cand) && (m_req_addr[wr_id] == m_req_addr[rd_id]);

`ifdef DRM_ARB_FWD_EN
    assign rd_gnt = rd_cand;
`else
    // Stalled read keeps its priority (adv low) and wins next cycle.
    assign rd_gnt = hazard ? 2'b00 : rd_cand;
`endif

    assign m_req_ready = wr_gnt | rd_gnt;

    always_comb begin
        wr = '0;
        if (|wr_gnt) begin
            wr.en   = 1'b1;
            wr.addr = m_req_addr[wr_id];
            wr.data = m_req_wdata[wr_id];
            wr.be   = m_req_be[wr_id];
        end
    end

    assign ram_wr_en      = wr.en;
    assign ram_wr_addr    = wr.addr;
    assign ram_wr_data    = wr.data;
    assign ram_wr_byte_en = wr.be;
    assign ram_rd_addr    = rst ? '0 : ((|rd_gnt) ? m_req_addr[rd_id] : rd_addr_q);

`ifdef DRM_ARB_FWD_EN
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [BE_WIDTH-1:0]   fwd_be;

    // RAM returns pre-write data on a same-cycle collision; patch written lanes.
    always_comb begin
        rsp_data = ram_rd_data;
        for (int b = 0; b < BE_WIDTH; b++)
            if (fwd_hit && fwd_be[b])
                rsp_data[b*8 +: 8] = fwd_data[b*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
            fwd_be   <= '0;
        end else begin
            fwd_hit  <= hazard;
            fwd_data <= m_req_wdata[wr_id];
            fwd_be   <= m_req_be[wr_id];
        end
    end
`else
    assign rsp_data = ram_rd_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q <= '0;
            rsp_pend  <= 1'b0;
            rsp_id    <= 1'b0;
        end else begin
            if (|rd_gnt)
                rd_addr_q <= m_req_addr[rd_id];
            rsp_pend <= |rd_gnt;
            rsp_id   <= rd_id;
        end
    end

    // A response due in a reset cycle is dropped.
    assign m_rsp_valid = (rsp_pend && !rst) ? {rsp_id, ~rsp_id} : 2'b00;
    assign m_rsp_rdata = (m_rsp_valid != 2'b00) ? rsp_data : '0;

endmodule

// File: tb/tb_drm_data2_arb.sv
// tb_drm_data2_arb: directed bench for drm_data2_arb with a RAM model, a
// per-cycle reference model of the arbitration rules and literal checks.
module tb_drm_data2_arb;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       m_req_valid, m_req_ready, m_req_we, m_rsp_valid;
    logic [1:0][9:0]  m_req_addr;
    logic [1:0][7:0]  m_req_wdata;
    logic [1:0][0:0]  m_req_be;
    logic [7:0]       m_rsp_rdata;
    logic             ram_wr_en;
    logic [9:0]       ram_wr_addr, ram_rd_addr;
    logic [7:0]       ram_wr_data, ram_rd_data;
    logic [0:0]       ram_wr_byte_en;

    int checks = 0;
    int failures = 0;

    drm_data2_arb dut (
        .clk(clk), .rst(rst),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
        .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_be(m_req_be),
        .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_wr_byte_en(ram_wr_byte_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;

    // RAM: read-first simple dual port, latency 1
    logic [7:0] mem [0:1023];
    always @(posedge clk) begin
        ram_rd_data <= mem[ram_rd_addr];
        if (ram_wr_en && ram_wr_byte_en[0])
            mem[ram_wr_addr] <= ram_wr_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory contents as seen by masters, priority owners,
    // and the response owed next cycle.
    logic [7:0] refmem [0:1023];
    int         wptr = 0, rptr = 0;
    bit         pend = 0;
    int         pend_id = 0;
    logic [7:0] pend_data = 0;

    always @(negedge clk) begin
        logic [1:0] wc, rc, erdy, erv;
        logic [7:0] erd;
        int ww, rw;
        erv = (!rst && pend) ? ((pend_id == 1) ? 2'b10 : 2'b01) : 2'b00;
        erd = (erv != 0) ? pend_data : 8'h00;
        wc  = rst ? 2'b00 : (m_req_valid &  m_req_we);
        rc  = rst ? 2'b00 : (m_req_valid & ~m_req_we);
        ww = -1; rw = -1;
        if (wc[wptr]) ww = wptr; else if (wc[1-wptr]) ww = 1 - wptr;
        if (rc[rptr]) rw = rptr; else if (rc[1-rptr]) rw = 1 - rptr;
`ifndef DRM_ARB_FWD_EN
        if (ww >= 0 && rw >= 0 && m_req_addr[ww] == m_req_addr[rw]) rw = -1;
`endif
        erdy = 2'b00;
        if (ww >= 0) erdy[ww] = 1'b1;
        if (rw >= 0) erdy[rw] = 1'b1;
        chk("mdl_ready",     32'(m_req_ready), 32'(erdy));
        chk("mdl_rsp_valid", 32'(m_rsp_valid), 32'(erv));
        chk("mdl_rsp_rdata", 32'(m_rsp_rdata), 32'(erd));
        chk("mdl_wr_en",     32'(ram_wr_en),   32'(ww >= 0));
        if (ww >= 0) begin
            chk("mdl_wr_addr", 32'(ram_wr_addr),    32'(m_req_addr[ww]));
            chk("mdl_wr_data", 32'(ram_wr_data),    32'(m_req_wdata[ww]));
            chk("mdl_wr_be",   32'(ram_wr_byte_en), 32'(m_req_be[ww]));
        end
        if (rw >= 0) chk("mdl_rd_addr", 32'(ram_rd_addr), 32'(m_req_addr[rw]));
        if (rst) begin
            wptr = 0; rptr = 0; pend = 0;
        end else begin
            if (ww >= 0) begin
                if (m_req_be[ww][0]) refmem[m_req_addr[ww]] = m_req_wdata[ww];
                wptr = 1 - ww;
            end
            pend = 0;
            if (rw >= 0) begin
                pend = 1; pend_id = rw; pend_data = refmem[m_req_addr[rw]];
                rptr = 1 - rw;
            end
        end
    end

    task automatic req(input logic [1:0] v, input logic [1:0] we,
                       input logic [9:0] a0, input logic [7:0] d0,
                       input logic [9:0] a1, input logic [7:0] d1,
                       input logic [1:0] be);
        m_req_valid = v; m_req_we = we;
        m_req_addr[0] = a0; m_req_wdata[0] = d0; m_req_be[0] = be[0];
        m_req_addr[1] = a1; m_req_wdata[1] = d1; m_req_be[1] = be[1];
    endtask

    // Check hand-computed ready / response for the current cycle, then advance.
    task automatic tick(input string nm, input logic [1:0] rdy,
                        input logic [1:0] rv, input logic [7:0] rd);
        @(negedge clk);
        #1;
        chk({nm, "_ready"}, 32'(m_req_ready), 32'(rdy));
        chk({nm, "_rsp_valid"}, 32'(m_rsp_valid), 32'(rv));
        chk({nm, "_rsp_rdata"}, 32'(m_rsp_rdata), 32'(rd));
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin mem[i] = 8'h00; refmem[i] = 8'h00; end
        mem[10'h000] = 8'h11; refmem[10'h000] = 8'h11;
        mem[10'h040] = 8'h77; refmem[10'h040] = 8'h77;
        ram_rd_data = 8'h00;
        rst = 1'b1;
        req(2'b11, 2'b11, 10'h010, 8'hAA, 10'h011, 8'h55, 2'b11);

        // reset held with both masters requesting
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_wr_en", 32'(ram_wr_en), 32'd0);
            @(posedge clk); #1;
        end
        tick("rst", 2'b00, 2'b00, 8'h00);
        rst = 1'b0;

        // write contention alternates m0, m1, m0
        tick("wr_rr0", 2'b01, 2'b00, 8'h00);
        tick("wr_rr1", 2'b10, 2'b00, 8'h00);
        tick("wr_rr2", 2'b01, 2'b00, 8'h00);
        req(2'b01, 2'b00, 10'h010, 8'h00, 10'h000, 8'h00, 2'b00);
        tick("rb_req", 2'b01, 2'b00, 8'h00);
        req(2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b00);
        tick("rb_rsp", 2'b00, 2'b01, 8'hAA);

        // concurrent write (top address) and read
        req(2'b11, 2'b01, 10'h3FF, 8'h5A, 10'h000, 8'h00, 2'b01);
        tick("conc", 2'b11, 2'b00, 8'h00);
        req(2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b00);
        tick("conc_rsp", 2'b00, 2'b10, 8'h11);

        // same-address write/read collision
        req(2'b11, 2'b01, 10'h020, 8'hC3, 10'h020, 8'h00, 2'b01);
`ifdef DRM_ARB_FWD_EN
        tick("haz", 2'b11, 2'b00, 8'h00);
`else
        tick("haz_stall", 2'b01, 2'b00, 8'h00);
        req(2'b10, 2'b00, 10'h020, 8'h00, 10'h020, 8'h00, 2'b00);
        tick("haz_rd", 2'b10, 2'b00, 8'h00);
`endif
        req(2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b00);
        tick("haz_rsp", 2'b00, 2'b10, 8'hC3);

        // reset the cycle after a read grant: response dropped, pointers to m0
        req(2'b01, 2'b00, 10'h011, 8'h00, 10'h000, 8'h00, 2'b00);
        tick("mid_rd", 2'b01, 2'b00, 8'h00);
        req(2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b00);
        rst = 1'b1;
        tick("mid_rst", 2'b00, 2'b00, 8'h00);
        rst = 1'b0;
        tick("mid_none", 2'b00, 2'b00, 8'h00);
        req(2'b11, 2'b00, 10'h010, 8'h00, 10'h011, 8'h00, 2'b00);
        tick("rd_ptr_rst", 2'b01, 2'b00, 8'h00);
        req(2'b10, 2'b00, 10'h010, 8'h00, 10'h011, 8'h00, 2'b00);
        tick("rd_ptr_m1", 2'b10, 2'b01, 8'hAA);
        req(2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b00);
        tick("rd_rsp_m1", 2'b00, 2'b10, 8'h55);
        req(2'b11, 2'b11, 10'h050, 8'h01, 10'h051, 8'h02, 2'b11);
        tick("wr_ptr_rst", 2'b01, 2'b00, 8'h00);
        req(2'b10, 2'b11, 10'h050, 8'h01, 10'h051, 8'h02, 2'b11);
        tick("wr_ptr_m1", 2'b10, 2'b00, 8'h00);

        // byte enable low leaves memory unchanged
        req(2'b01, 2'b01, 10'h040, 8'hEE, 10'h000, 8'h00, 2'b00);
        tick("be0_wr", 2'b01, 2'b00, 8'h00);
        req(2'b01, 2'b00, 10'h040, 8'h00, 10'h000, 8'h00, 2'b00);
        tick("be0_rd", 2'b01, 2'b00, 8'h00);
        req(2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b00);
        tick("be0_rsp", 2'b00, 2'b01, 8'h77);

        // readback of the top address written earlier
        req(2'b10, 2'b00, 10'h000, 8'h00, 10'h3FF, 8'h00, 2'b00);
        tick("rd3ff", 2'b10, 2'b00, 8'h00);
        req(2'b00, 2'b00, 10'h000, 8'h00, 10'h000, 8'h00, 2'b00);
        tick("rd3ff_rsp", 2'b00, 2'b10, 8'h5A);
        tick("idle", 2'b00, 2'b00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
